// File: rtl/score4_move_support.sv
// score4_move_support: button release pulses, column encoder and free-row finder for Score 4
module score4_move_support (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  left,
    input  logic                  right,
    input  logic                  put,
    input  logic [6:0][5:0][1:0]  panel,
    input  logic [6:0]            play,
    output logic                  l_pulse,
    output logic                  r_pulse,
    output logic                  p_pulse,
    output logic [2:0]            column,
    output logic [2:0]            free,
    output logic                  valid
);

    logic [2:0] prev;

    // previous button levels, ordered {put, right, left}
    always_ff @(posedge clk)
        prev <= rst ? 3'b000 : {put, right, left};

    assign l_pulse = prev[0] & ~left;
    assign r_pulse = prev[1] & ~right;
    assign p_pulse = prev[2] & ~put;

    // lowest set bit of play wins; no selection falls back to column 0
    always_comb begin
        column = 3'd0;
        for (int i = 6; i >= 0; i--)
            if (play[i]) column = i[2:0];
    end

    // lowest empty row of the selected column; full column reports row 0, invalid
    always_comb begin
        free  = 3'd0;
        valid = 1'b0;
        for (int r = 5; r >= 0; r--)
            if (panel[column][r] == 2'b00) begin
                free  = r[2:0];
                valid = 1'b1;
            end
    end

endmodule

// File: tb/tb_score4_move_support.sv
// tb_score4_move_support: scoreboard bench for button pulses and move lookup
module tb_score4_move_support;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 left = 1'b0;
    logic                 right = 1'b0;
    logic                 put = 1'b0;
    logic [6:0][5:0][1:0] panel = '0;
    logic [6:0]           play = 7'd1;
    logic                 l_pulse, r_pulse, p_pulse, valid;
    logic [2:0]           column, free;

    logic [31:0] sb[$];
    int n_cmp = 0;
    int n_err = 0;

    score4_move_support dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
        .panel(panel), .play(play),
        .l_pulse(l_pulse), .r_pulse(r_pulse), .p_pulse(p_pulse),
        .column(column), .free(free), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // one clock: drive levels after the edge, expect {l,r,p} pulses at the next negedge
    task automatic cyc(input string tag, input logic r_in, input logic l_in,
                       input logic ri_in, input logic p_in, input logic [2:0] e);
        rst = r_in; left = l_in; right = ri_in; put = p_in;
        sb.push_back({29'd0, e});
        @(negedge clk);
        if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else chk(tag, {29'd0, l_pulse, r_pulse, p_pulse}, sb.pop_front());
        @(posedge clk);
        #1;
    endtask

    // combinational lookup: expected {column, free, valid}
    task automatic look(input string tag, input logic [6:0] pl,
                        input logic [2:0] ec, input logic [2:0] ef, input logic ev);
        play = pl;
        sb.push_back({25'd0, ec, ef, ev});
        #1;
        if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else chk(tag, {25'd0, column, free, valid}, sb.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        cyc("rst0", 1, 1, 0, 0, 3'b000);
        cyc("rst1", 1, 1, 0, 0, 3'b000);
        cyc("rst_release_in_reset", 1, 0, 0, 0, 3'b000);
        cyc("rst3", 1, 1, 0, 0, 3'b000);
        for (int i = 0; i < 5; i++) cyc("hold_left", 0, 1, 0, 0, 3'b000);
        cyc("left_release", 0, 0, 0, 0, 3'b100);
        cyc("left_after", 0, 0, 0, 0, 3'b000);
        cyc("left_low", 0, 0, 0, 0, 3'b000);
        for (int n = 0; n < 3; n++) begin
            cyc("put_rise", 0, 0, 0, 1, 3'b000);
            for (int i = 0; i < 9; i++) cyc("put_hold", 0, 0, 0, 1, 3'b000);
            cyc("put_release", 0, 0, 0, 0, 3'b001);
            cyc("put_after", 0, 0, 0, 0, 3'b000);
        end
        cyc("lr_press", 0, 1, 1, 0, 3'b000);
        cyc("lr_hold", 0, 1, 1, 0, 3'b000);
        cyc("lr_release", 0, 0, 0, 0, 3'b110);
        cyc("lr_after", 0, 0, 0, 0, 3'b000);
        cyc("r_press", 0, 0, 1, 1, 3'b000);
        cyc("r_release", 0, 0, 0, 1, 3'b010);
        cyc("p_release", 0, 0, 0, 0, 3'b001);
        cyc("all_press", 0, 1, 1, 1, 3'b000);
        cyc("all_release", 0, 0, 0, 0, 3'b111);
        cyc("all_after", 0, 0, 0, 0, 3'b000);

        panel = '0;
        panel[4][0] = 2'b10;
        panel[4][1] = 2'b01;
        for (int c = 0; c < 7; c++) begin
            logic [6:0] pl;
            pl = 7'd1 << c;
            look("col_sweep", pl, c[2:0], (c == 4) ? 3'd2 : 3'd0, 1'b1);
        end
        look("col_multi", 7'b0010100, 3'd2, 3'd0, 1'b1);
        look("col_none", 7'b0000000, 3'd0, 3'd0, 1'b1);
        look("free_empty", 7'b0001000, 3'd3, 3'd0, 1'b1);
        panel[3][0] = 2'b01;
        panel[3][1] = 2'b10;
        panel[3][2] = 2'b01;
        look("free_row3", 7'b0001000, 3'd3, 3'd3, 1'b1);
        look("col4_part", 7'b0010000, 3'd4, 3'd2, 1'b1);
        look("multi_34", 7'b0011000, 3'd3, 3'd3, 1'b1);
        panel[3][3] = 2'b10;
        panel[3][4] = 2'b01;
        look("free_row5", 7'b0001000, 3'd3, 3'd5, 1'b1);
        panel[3][5] = 2'b10;
        look("free_full", 7'b0001000, 3'd3, 3'd0, 1'b0);
        look("col4_still", 7'b0010000, 3'd4, 3'd2, 1'b1);
        panel[5][0] = 2'b01;
        panel[5][1] = 2'b11;
        look("hole_11", 7'b0100000, 3'd5, 3'd2, 1'b1);
        panel[0][0] = 2'b11;
        look("none_col0", 7'b0000000, 3'd0, 3'd1, 1'b1);
        for (int r = 0; r < 6; r++) panel[6][r] = 2'b11;
        look("full_11", 7'b1000000, 3'd6, 3'd0, 1'b0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
